// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//
// Bit-serial two's-complement adder/subtractor. Operands are captured on a
// start request, then one bit per clock is processed LSB first through a
// single full-adder cell with a registered carry. The result, carry-out and
// signed overflow are presented with a one-cycle done pulse.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     request; accepted only in IDLE or DONE
//   sub       0 = a+b, 1 = a-b; sampled with start
//   a, b      WIDTH-bit operands; sampled with start
//   busy      high while the operation is running
//   done      one-cycle pulse; result/c_out/overflow valid
//   result    WIDTH-bit sum or difference
//   c_out     carry out of the MSB (for subtract: 1 = no borrow)
//   overflow  signed overflow
// -----------------------------------------------------------------------------
module serial_add_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Full-adder cell on the current LSBs.
    logic sum_bit;
    logic carry_next;

    assign sum_bit    = opa[0] ^ opb[0] ^ carry;
    assign carry_next = (opa[0] & opb[0]) | ((opa[0] ^ opb[0]) & carry);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            opa      <= '0;
            opb      <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        opa      <= a;
                        // Subtraction as a + ~b + 1: invert b, seed carry with 1.
                        opb      <= sub ? ~b : b;
                        carry    <= sub;
                        cnt      <= '0;
                        result   <= '0;
                        c_out    <= 1'b0;
                        overflow <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    opa    <= opa >> 1;
                    opb    <= opb >> 1;
                    result <= {sum_bit, result[WIDTH-1:1]};
                    carry  <= carry_next;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        c_out    <= carry_next;
                        // On the MSB edge the registered carry is the carry
                        // into the MSB, so it is used directly rather than
                        // being latched into a separate register first.
                        overflow <= carry ^ carry_next;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
//
// Directed and random checks of serial_add_sub (WIDTH = 8): single-bit cases,
// wrap/overflow, subtraction, ignored restart, back-to-back operation, reset
// mid-operation and during DONE, and a random sweep against an integer model.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         c_out;
    logic         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    serial_add_sub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_busy"},     busy,     0);
        check({tag, "_done"},     done,     0);
        check({tag, "_result"},   result,   0);
        check({tag, "_c_out"},    c_out,    0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    // Issues one operation and follows it to its done cycle. Returns 1 time
    // unit after edge W (inside the DONE cycle), so a following call accepts
    // back-to-back at edge W+1. poke pulses start with other operands mid-RUN.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic ts, input logic [W-1:0] er,
                          input logic ec, input logic eo, input bit poke);
        a = ta; b = tb; sub = ts; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a   = W'($urandom);
        b   = W'($urandom);
        sub = 1'($urandom);
        check("busy_e0", busy, 1);
        check("done_e0", done, 0);
        for (int i = 1; i < W; i++) begin
            if (poke && i == 3) begin
                start = 1'b1; a = 8'h55; b = 8'h0F; sub = 1'b0;
            end
            @(posedge clk); #1;
            start = 1'b0;
            check("busy_run", busy, 1);
            check("done_run", done, 0);
        end
        @(posedge clk); #1;
        check("done_pulse", done,     1);
        check("busy_done",  busy,     0);
        check("result",     result,   32'(er));
        check("c_out",      c_out,    32'(ec));
        check("overflow",   overflow, 32'(eo));
    endtask

    // One cycle with start low: done must fall and the block returns to IDLE.
    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk); #1;
        check("done_fall", done, 0);
        check("busy_idle", busy, 0);
    endtask

    // Reference with wide integer arithmetic.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] mr, output logic mc, output logic mo);
        logic [W:0] t;
        int sa, sb, r;
        t  = {1'b0, ma} + {1'b0, (ms ? ~mb : mb)} + (W+1)'(ms);
        mr = t[W-1:0];
        mc = t[W];
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        r  = ms ? (sa - sb) : (sa + sb);
        mo = (r > 127) || (r < -128);
    endtask

    initial begin
        logic [W-1:0] ra, rb, er;
        logic         rs, ec, eo;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #3;
        check_cleared("reset");
        #4 rst = 1'b0;

        // Single-bit cell mirrors.
        run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
        idle_cycle();
        run_op(8'h00, 8'h01, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
        idle_cycle();

        // Wrap, overflow, subtraction, chained back-to-back.
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op(8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
        idle_cycle();

        // Restart request during RUN is ignored; then start held in DONE.
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);
        run_op(8'h20, 8'h05, 1'b1, 8'h1B, 1'b1, 1'b0, 1'b0);
        idle_cycle();

        // Reset four cycles into RUN clears everything without a clock edge.
        a = 8'hFF; b = 8'h00; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("busy_mid", busy, 1);
        #2 rst = 1'b1;
        #1;
        check_cleared("rst_mid");
        @(posedge clk); #1;
        check_cleared("rst_hold");
        rst = 1'b0;
        run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
        idle_cycle();

        // Reset during DONE clears held result, c_out and overflow.
        run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_cleared("rst_done");
        #2 rst = 1'b0;

        // Random sweep, each operation chained to the previous one.
        for (int n = 0; n < 500; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            model(ra, rb, rs, er, ec, eo);
            run_op(ra, rb, rs, er, ec, eo, 1'b0);
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
